// File: rtl/seq_divider_4.sv
// ============================================================================
// Module  : seq_divider_4
// Brief   : Multi-cycle unsigned restoring divider, one quotient bit per clock,
//           with a start/busy/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH:0]   r_rem;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_quo_next;

  // One restoring step: bring in the next dividend bit, keep the trial only if it did not borrow.
  always_comb begin
    w_accept   = start && (r_state != S_RUN);
    w_shift    = (r_rem << 1) | {{WIDTH{1'b0}}, r_dvd[WIDTH-1]};
    w_trial    = w_shift - {1'b0, r_dvs};
    w_qbit     = ~w_trial[WIDTH];
    w_rem_next = w_qbit ? w_trial : w_shift;
    w_quo_next = (r_quo << 1) | {{(WIDTH-1){1'b0}}, w_qbit};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= dividend;
      r_dvs <= divisor;
      r_quo <= '0;
      r_rem <= '0;
      r_cnt <= CW'(WIDTH);
      if (divisor == '0) begin
        // No iterations: result is defined directly and reported next cycle.
        r_state     <= S_DONE;
        busy        <= 1'b0;
        done        <= 1'b1;
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        r_state     <= S_RUN;
        busy        <= 1'b1;
        done        <= 1'b0;
        div_by_zero <= 1'b0;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_dvd <= r_dvd << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            quotient  <= w_quo_next;
            remainder <= w_rem_next[WIDTH-1:0];
            r_state   <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider_4.sv
// ============================================================================
// Module  : tb_seq_divider_4
// Brief   : Directed self-checking bench for seq_divider_4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider_4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  seq_divider_4 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done. k counts edges after
  // the accepting edge until done is visible; bcnt counts busy cycles.
  task automatic launch(input logic [3:0] a, input logic [3:0] b,
                        output int k, output int bcnt, output bit changed,
                        output logic z_after_e0);
    logic [3:0] pq, pr;
    @(negedge clk);
    pq = quotient;
    pr = remainder;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(negedge clk);
    start = 1'b0;
    z_after_e0 = div_by_zero;
    k = 0;
    bcnt = 0;
    changed = 1'b0;
    while (!done && k < 20) begin
      if (busy) bcnt++;
      if (quotient !== pq || remainder !== pr) changed = 1'b1;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    int k, bcnt;
    bit changed;
    logic z0;
    rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_async: got q=%0d r=%0d busy=%0b done=%0b dz=%0b, expected all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    launch(4'd7, 4'd2, k, bcnt, changed, z0);
    n_vec++;
    if (k !== 4) begin n_err++; $display("FAIL reset_7_2_latency: got %0d expected 4", k); end
    n_vec++;
    if (bcnt !== 4) begin n_err++; $display("FAIL reset_7_2_busy_cycles: got %0d expected 4", bcnt); end
    n_vec++;
    if ({quotient, remainder, div_by_zero} !== {4'd3, 4'd1, 1'b0}) begin
      n_err++;
      $display("FAIL reset_7_2_result: got q=%0d r=%0d dz=%0b expected q=3 r=1 dz=0",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got done=%0b expected 0", done); end
  endtask

  task automatic test_boundaries();
    logic [3:0] ta [4] = '{4'd15, 4'd15, 4'd5, 4'd0};
    logic [3:0] tb [4] = '{4'd1,  4'd15, 4'd7, 4'd3};
    logic [3:0] tq [4] = '{4'd15, 4'd1,  4'd0, 4'd0};
    logic [3:0] tr [4] = '{4'd0,  4'd0,  4'd5, 4'd0};
    int k, bcnt;
    bit changed;
    logic z0;
    for (int i = 0; i < 4; i++) begin
      launch(ta[i], tb[i], k, bcnt, changed, z0);
      n_vec++;
      if (k !== 4) begin n_err++; $display("FAIL bound_%0d_%0d_latency: got %0d expected 4", ta[i], tb[i], k); end
      n_vec++;
      if (quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
        n_err++;
        $display("FAIL bound_%0d_%0d_result: got q=%0d r=%0d dz=%0b expected q=%0d r=%0d dz=0",
                 ta[i], tb[i], quotient, remainder, div_by_zero, tq[i], tr[i]);
      end
      n_vec++;
      if (changed) begin n_err++; $display("FAIL bound_%0d_%0d_no_intermediate: got changed=1 expected 0", ta[i], tb[i]); end
    end
  endtask

  task automatic test_div_zero();
    int k, bcnt;
    bit changed;
    logic z0;
    launch(4'd9, 4'd0, k, bcnt, changed, z0);
    n_vec++;
    if (k !== 0 || bcnt !== 0) begin
      n_err++;
      $display("FAIL dz_latency: got k=%0d busy=%0d expected k=0 busy=0", k, bcnt);
    end
    n_vec++;
    if ({quotient, remainder, div_by_zero, done} !== {4'd15, 4'd9, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL dz_result: got q=%0d r=%0d dz=%0b done=%0b expected q=15 r=9 dz=1 done=1",
               quotient, remainder, div_by_zero, done);
    end
    launch(4'd8, 4'd4, k, bcnt, changed, z0);
    n_vec++;
    if (z0 !== 1'b0) begin n_err++; $display("FAIL dz_clear_at_accept: got %0b expected 0", z0); end
    n_vec++;
    if ({quotient, remainder, div_by_zero} !== {4'd2, 4'd0, 1'b0} || k !== 4) begin
      n_err++;
      $display("FAIL dz_next_8_4: got q=%0d r=%0d dz=%0b k=%0d expected q=2 r=0 dz=0 k=4",
               quotient, remainder, div_by_zero, k);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(negedge clk);
    dividend = 4'd12; divisor = 4'd5;
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    n_vec++;
    if (k !== 4 || quotient !== 4'd3 || remainder !== 4'd1) begin
      n_err++;
      $display("FAIL busy_ignore: got q=%0d r=%0d k=%0d expected q=3 r=1 k=4", quotient, remainder, k);
    end
    // start still high during the DONE cycle: accepted on the next edge
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL accept_in_done: got busy=%0b done=%0b expected busy=1 done=0", busy, done);
    end
    k = 0;
    while (!done && k < 20) begin @(negedge clk); k++; end
    n_vec++;
    if (k !== 4 || quotient !== 4'd2 || remainder !== 4'd2) begin
      n_err++;
      $display("FAIL back_to_back_12_5: got q=%0d r=%0d k=%0d expected q=2 r=2 k=4", quotient, remainder, k);
    end
  endtask

  task automatic test_reset_mid_run();
    int k, bcnt, spurious;
    bit changed;
    logic z0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_mid_run: got q=%0d r=%0d busy=%0b done=%0b dz=%0b expected all 0",
               quotient, remainder, busy, done, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (8) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    n_vec++;
    if (spurious !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d active cycles expected 0", spurious); end
    launch(4'd14, 4'd3, k, bcnt, changed, z0);
    n_vec++;
    if (k !== 4 || quotient !== 4'd4 || remainder !== 4'd2) begin
      n_err++;
      $display("FAIL after_abort_14_3: got q=%0d r=%0d k=%0d expected q=4 r=2 k=4", quotient, remainder, k);
    end
  endtask

  task automatic test_sweep();
    int k, bcnt, exp_k;
    bit changed;
    logic z0;
    logic [3:0] eq, er;
    logic ez;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(4'(a), 4'(b), k, bcnt, changed, z0);
        if (b == 0) begin
          eq = 4'd15; er = 4'(a); ez = 1'b1; exp_k = 0;
        end else begin
          eq = 4'(a / b); er = 4'(a % b); ez = 1'b0; exp_k = 4;
        end
        n_vec++;
        if (quotient !== eq || remainder !== er || div_by_zero !== ez || k !== exp_k || done !== 1'b1) begin
          n_err++;
          $display("FAIL sweep_%0d_%0d: got q=%0d r=%0d dz=%0b k=%0d expected q=%0d r=%0d dz=%0b k=%0d",
                   a, b, quotient, remainder, div_by_zero, k, eq, er, ez, exp_k);
        end
        if (b != 0) begin
          n_vec++;
          if (int'(quotient) * b + int'(remainder) != a || int'(remainder) >= b) begin
            n_err++;
            $display("FAIL invariant_%0d_%0d: got q=%0d r=%0d expected a=q*b+r with r<b",
                     a, b, quotient, remainder);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_boundaries();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_divider_4.md
Name: seq_divider_4

Overview:
Multi-cycle unsigned restoring divider and the inverse companion of the team's ripple adder. It computes quotient and remainder of dividend/divisor by repeated trial subtraction, resolving one quotient bit per clock. It sits beside the adder inside the ALU and handles the divide opcode. It uses a start/busy/done handshake toward the ALU controller.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (WIDTH >= 2).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new division; sampled on clk rising edge
dividend  input  WIDTH  unsigned numerator; sampled only when start is accepted
divisor  input  WIDTH  unsigned denominator; sampled only when start is accepted
quotient  output  WIDTH  registered quotient; holds the last result until the next accepted start
remainder  output  WIDTH  registered remainder; holds the last result until the next accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse marking that quotient/remainder/div_by_zero are valid
div_by_zero  output  1  set with done when divisor was 0; holds until the next accepted start

Behaviour:
- Reset: one clock, asynchronous and active-low; clk and rst_n are the only clock/reset ports.
- rst_n low forces, immediately and independent of clk: state=IDLE; quotient, remainder, busy, done, div_by_zero = 0; all internal registers = 0.
- Reset mid-operation aborts the operation. No done is produced for it.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE.
- Accepting start: start is accepted on an edge where busy=0, i.e. in IDLE or DONE, so back-to-back operations are allowed. On an accepted edge E0:
  - latch dividend and divisor;
  - clear div_by_zero;
  - clear the partial remainder (WIDTH+1 bits);
  - load the iteration counter with WIDTH.
- start while busy=1 is ignored. Operands, outputs and timing are unaffected.
- Divisor zero at E0: no iterations run. Next state is DONE with quotient = all ones, remainder = dividend, div_by_zero=1. done is high in the cycle after E0 (latency 1).
- Normal path: next state is RUN. On each RUN edge, MSB-first, one step:
  - shift the partial remainder left by 1, bringing in the next dividend bit;
  - trial = partial remainder - {0,divisor}, computed in WIDTH+1 bits;
  - if trial is non-negative (MSB 0): partial remainder = trial, quotient bit = 1;
  - otherwise: restore (partial remainder unchanged), quotient bit = 0;
  - decrement the counter.
- The RUN edge that uses the last iteration (counter 1 -> 0) also registers quotient and remainder (low WIDTH bits of the partial remainder) and moves to DONE.
- Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH cycles after acceptance. busy is high for exactly WIDTH cycles.
- quotient and remainder outputs change only on a DONE entry or on reset; they are never updated with intermediate values.
- Invariant at every done: dividend = quotient*divisor + remainder and remainder < divisor (divisor != 0).
- No overflow is possible for unsigned operands: quotient <= dividend.

Test Plan:
1. Reset with rst_n=0 held mid-cycle -> all outputs 0 immediately, no clk edge needed; release, then start 7/2 -> busy high 4 cycles, done pulse 1 cycle, quotient=3, remainder=1, div_by_zero=0.
2. Boundaries: 15/1 -> 15,0; 15/15 -> 1,0; 5/7 -> 0,5; 0/3 -> 0,0; each with done exactly 4 cycles after acceptance.
3. Divide by zero: 9/0 -> done the cycle after acceptance, quotient=15, remainder=9, div_by_zero=1; next op 8/4 -> 2,0 with div_by_zero cleared at acceptance.
4. start held high with new operands 12/5 during busy -> ignored, result 7/2 = 3,1. start asserted during the DONE cycle with 12/5 -> accepted, result 2,2 after 4 more cycles.
5. rst_n pulsed low at cycle 2 of RUN -> no done, outputs 0, returns to IDLE; subsequent 14/3 -> 4,2.
6. Exhaustive sweep of all 256 operand pairs, checking the invariant and the div_by_zero case against a reference model.
